// File: rtl/draw_mem_exec_unit_if.sv
// Bundles the request/status, VGA-pixel and RAM signals of draw_mem_exec_unit.
// The master side is the controller/RAM environment; the slave side is the unit.
interface draw_mem_exec_unit_if #(
   parameter int unsigned INSTR_W  = 32,
   parameter int unsigned X_W      = 8,
   parameter int unsigned Y_W      = 7,
   parameter int unsigned COLOUR_W = 3,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 12
);
   logic                start;
   logic [INSTR_W-1:0]  instruction;
   logic [DATA_W-1:0]   result;
   logic [X_W-1:0]      x;
   logic [Y_W-1:0]      y;
   logic [COLOUR_W-1:0] colour;
   logic                plot;
   logic                finished;
   logic                illegal;
   logic [DATA_W-1:0]   mem_output;
   logic [ADDR_W-1:0]   mem_address;
   logic [DATA_W-1:0]   mem_data;
   logic                mem_write;

   modport master (
      output start, instruction, mem_output,
      input  result, x, y, colour, plot, finished, illegal,
             mem_address, mem_data, mem_write
   );

   modport slave (
      input  start, instruction, mem_output,
      output result, x, y, colour, plot, finished, illegal,
             mem_address, mem_data, mem_write
   );
endinterface

// File: rtl/draw_mem_exec_unit.sv
// Single-instruction execution unit: PLOT, LOAD, STORE, RECT (pixel fill) and
// FILL (memory range fill), one instruction per start/finished handshake.
module draw_mem_exec_unit #(
   parameter int unsigned OP_W        = 4,
   parameter int unsigned INSTR_W     = 32,
   parameter int unsigned X_W         = 8,
   parameter int unsigned Y_W         = 7,
   parameter int unsigned COLOUR_W    = 3,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 12,
   parameter int unsigned RECT_W      = 5,
   parameter int unsigned CNT_W       = 12,
   parameter int unsigned MEM_LATENCY = 2
) (
   input logic                 clock,
   input logic                 resetn,
   draw_mem_exec_unit_if.slave bus
);
   localparam int unsigned Y_LSB = X_W;
   localparam int unsigned C_LSB = X_W + Y_W;
   localparam int unsigned P_LSB = C_LSB + COLOUR_W;
   localparam int unsigned H_LSB = P_LSB + RECT_W;

   typedef enum logic [2:0] {S_IDLE, S_PLOT, S_MEMWAIT, S_RECT, S_FILL} state_t;
   typedef enum logic [OP_W-1:0] {
      OP_PLOT  = OP_W'(1),
      OP_LOAD  = OP_W'(2),
      OP_STORE = OP_W'(3),
      OP_RECT  = OP_W'(4),
      OP_FILL  = OP_W'(5)
   } opcode_t;

   state_t              state_q, state_d;
   logic [INSTR_W-1:0]  instr_q, instr_d;
   logic [X_W-1:0]      x_q, x_d;
   logic [Y_W-1:0]      y_q, y_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;
   logic                plot_q, plot_d;
   logic                finished_q, finished_d;
   logic                illegal_q, illegal_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                wr_q, wr_d;
   logic [RECT_W-1:0]   rect_i_q, rect_i_d;
   logic [RECT_W-1:0]   rect_j_q, rect_j_d;
   logic [CNT_W-1:0]    fill_n_q, fill_n_d;
   logic [2:0]          lat_q, lat_d;
   logic                done_q, done_d;

   logic [OP_W-1:0]     op_in, op_q;
   logic [X_W-1:0]      f_x0;
   logic [Y_W-1:0]      f_y0;
   logic [COLOUR_W-1:0] f_colour;
   logic                f_pen;
   logic [RECT_W-1:0]   f_wm1, f_hm1;
   logic [ADDR_W-1:0]   f_addr;
   logic [DATA_W-1:0]   f_data;
   logic [CNT_W-1:0]    f_cntm1;

   assign op_in    = bus.instruction[INSTR_W-1 -: OP_W];
   assign op_q     = instr_q[INSTR_W-1 -: OP_W];
   assign f_x0     = instr_q[X_W-1:0];
   assign f_y0     = instr_q[Y_LSB +: Y_W];
   assign f_colour = instr_q[C_LSB +: COLOUR_W];
   assign f_pen    = instr_q[P_LSB];
   assign f_wm1    = instr_q[P_LSB +: RECT_W];
   assign f_hm1    = instr_q[H_LSB +: RECT_W];
   assign f_addr   = instr_q[ADDR_W-1:0];
   assign f_data   = instr_q[ADDR_W +: DATA_W];
   assign f_cntm1  = instr_q[ADDR_W +: CNT_W];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         instr_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         colour_q   <= '0;
         plot_q     <= 1'b0;
         finished_q <= 1'b1;
         illegal_q  <= 1'b0;
         result_q   <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         wr_q       <= 1'b0;
         rect_i_q   <= '0;
         rect_j_q   <= '0;
         fill_n_q   <= '0;
         lat_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         x_q        <= x_d;
         y_q        <= y_d;
         colour_q   <= colour_d;
         plot_q     <= plot_d;
         finished_q <= finished_d;
         illegal_q  <= illegal_d;
         result_q   <= result_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wr_q       <= wr_d;
         rect_i_q   <= rect_i_d;
         rect_j_q   <= rect_j_d;
         fill_n_q   <= fill_n_d;
         lat_q      <= lat_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      x_d        = x_q;
      y_d        = y_q;
      colour_d   = colour_q;
      plot_d     = plot_q;
      finished_d = finished_q;
      illegal_d  = illegal_q;
      result_d   = result_q;
      addr_d     = addr_q;
      data_d     = data_q;
      wr_d       = wr_q;
      rect_i_d   = rect_i_q;
      rect_j_d   = rect_j_q;
      fill_n_d   = fill_n_q;
      lat_d      = lat_q;
      done_d     = done_q;

      case (state_q)
         S_IDLE: begin
            if (finished_q) begin
               if (bus.start) begin
                  instr_d    = bus.instruction;
                  finished_d = 1'b0;
                  illegal_d  = 1'b0;
                  rect_i_d   = '0;
                  rect_j_d   = '0;
                  fill_n_d   = '0;
                  lat_d      = '0;
                  done_d     = 1'b0;
                  case (op_in)
                     OP_PLOT:           state_d = S_PLOT;
                     OP_LOAD, OP_STORE: state_d = S_MEMWAIT;
                     OP_RECT:           state_d = S_RECT;
                     OP_FILL:           state_d = S_FILL;
                     default:           state_d = S_IDLE;
                  endcase
               end
            end else begin
               // Busy while idle only happens after an undefined opcode was accepted.
               finished_d = 1'b1;
               illegal_d  = 1'b1;
            end
         end

         S_PLOT: begin
            if (!done_q) begin
               x_d      = f_x0;
               y_d      = f_y0;
               colour_d = f_colour;
               plot_d   = f_pen;
               done_d   = 1'b1;
            end else begin
               plot_d     = 1'b0;
               finished_d = 1'b1;
               done_d     = 1'b0;
               state_d    = S_IDLE;
            end
         end

         S_MEMWAIT: begin
            if (lat_q == 3'd0) begin
               addr_d = f_addr;
               wr_d   = (op_q == OP_STORE);
               if (op_q == OP_STORE) data_d = f_data;
            end else begin
               wr_d = 1'b0;
            end
            if (lat_q == 3'(MEM_LATENCY)) begin
               if (op_q == OP_LOAD) result_d = bus.mem_output;
               finished_d = 1'b1;
               lat_d      = '0;
               state_d    = S_IDLE;
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end

         S_RECT: begin
            // Terminal tests compare against the m1 fields so all-ones sizes end cleanly.
            if (!done_q) begin
               x_d      = f_x0 + X_W'(rect_i_q);
               y_d      = f_y0 + Y_W'(rect_j_q);
               colour_d = f_colour;
               plot_d   = 1'b1;
               if (rect_i_q == f_wm1) begin
                  rect_i_d = '0;
                  if (rect_j_q == f_hm1) done_d = 1'b1;
                  else rect_j_d = rect_j_q + RECT_W'(1);
               end else begin
                  rect_i_d = rect_i_q + RECT_W'(1);
               end
            end else begin
               plot_d     = 1'b0;
               finished_d = 1'b1;
               done_d     = 1'b0;
               state_d    = S_IDLE;
            end
         end

         S_FILL: begin
            if (!done_q) begin
               addr_d = f_addr + ADDR_W'(fill_n_q);
               data_d = result_q;
               wr_d   = 1'b1;
               if (fill_n_q == f_cntm1) done_d = 1'b1;
               else fill_n_d = fill_n_q + CNT_W'(1);
            end else begin
               wr_d       = 1'b0;
               finished_d = 1'b1;
               done_d     = 1'b0;
               state_d    = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.result      = result_q;
   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.colour      = colour_q;
   assign bus.plot        = plot_q;
   assign bus.finished    = finished_q;
   assign bus.illegal     = illegal_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_data    = data_q;
   assign bus.mem_write   = wr_q;
endmodule

// File: tb/tb_draw_mem_exec_unit.sv
// Directed bench for draw_mem_exec_unit with a two-cycle-latency RAM model.
module tb_draw_mem_exec_unit;
   logic clock;
   logic resetn;
   int   checks;
   int   failures;

   logic [11:0] ram [0:65535];
   logic [11:0] rd_q;

   draw_mem_exec_unit_if #(
      .INSTR_W(32), .X_W(8), .Y_W(7), .COLOUR_W(3), .ADDR_W(16), .DATA_W(12)
   ) bus ();

   draw_mem_exec_unit #(
      .OP_W(4), .INSTR_W(32), .X_W(8), .Y_W(7), .COLOUR_W(3), .ADDR_W(16),
      .DATA_W(12), .RECT_W(5), .CNT_W(12), .MEM_LATENCY(2)
   ) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Address registered at E1, read register at E2, data sampled by the unit at E3.
   always @(posedge clock) begin
      if (!resetn) begin
         ram[16'h0010] <= 12'hABC;
         ram[16'h0020] <= 12'h5A5;
      end else if (bus.mem_write) begin
         ram[bus.mem_address] <= bus.mem_data;
      end
      rd_q <= ram[bus.mem_address];
   end
   assign bus.mem_output = rd_q;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_plot(input logic [7:0] x, input logic [6:0] y,
                                           input logic [2:0] c, input logic pen);
      return {4'd1, 9'd0, pen, c, y, x};
   endfunction

   function automatic logic [31:0] mk_rect(input logic [7:0] x, input logic [6:0] y,
                                           input logic [2:0] c, input logic [4:0] w,
                                           input logic [4:0] h);
      return {4'd4, h, w, c, y, x};
   endfunction

   function automatic logic [31:0] mk_mem(input logic [3:0] op, input logic [11:0] d,
                                          input logic [15:0] a);
      return {op, d, a};
   endfunction

   initial begin
      int ex [6];
      int ey [6];
      int wr;
      int cyc;
      int bad;
      checks   = 0;
      failures = 0;
      ex = '{254, 255, 0, 254, 255, 0};
      ey = '{10, 10, 10, 11, 11, 11};
      resetn = 1'b0;
      bus.start = 1'b0;
      bus.instruction = '0;
      tick();
      tick();
      chk("rst_finished", 32'(bus.finished), 1);
      chk("rst_plot", 32'(bus.plot), 0);
      chk("rst_illegal", 32'(bus.illegal), 0);
      chk("rst_memwr", 32'(bus.mem_write), 0);
      chk("rst_result", 32'(bus.result), 0);
      resetn = 1'b1;
      tick();

      // PLOT
      bus.start = 1'b1;
      bus.instruction = mk_plot(8'd160, 7'd120, 3'd5, 1'b1);
      tick();
      bus.start = 1'b0;
      chk("plot_e0_finished", 32'(bus.finished), 0);
      tick();
      chk("plot_e1_plot", 32'(bus.plot), 1);
      chk("plot_e1_x", 32'(bus.x), 160);
      chk("plot_e1_y", 32'(bus.y), 120);
      chk("plot_e1_colour", 32'(bus.colour), 5);
      chk("plot_e1_finished", 32'(bus.finished), 0);
      tick();
      chk("plot_e2_plot", 32'(bus.plot), 0);
      chk("plot_e2_finished", 32'(bus.finished), 1);
      tick();
      chk("plot_e3_x", 32'(bus.x), 160);
      chk("plot_e3_y", 32'(bus.y), 120);
      chk("plot_e3_colour", 32'(bus.colour), 5);
      chk("plot_e3_plot", 32'(bus.plot), 0);

      // LOAD 0x0010
      bus.start = 1'b1;
      bus.instruction = mk_mem(4'd2, 12'd0, 16'h0010);
      tick();
      bus.start = 1'b0;
      tick();
      chk("load_e1_addr", 32'(bus.mem_address), 'h10);
      chk("load_e1_memwr", 32'(bus.mem_write), 0);
      tick();
      chk("load_e2_finished", 32'(bus.finished), 0);
      tick();
      chk("load_e3_result", 32'(bus.result), 'hABC);
      chk("load_e3_finished", 32'(bus.finished), 1);

      // STORE 0x123 -> 0x0011
      bus.start = 1'b1;
      bus.instruction = mk_mem(4'd3, 12'h123, 16'h0011);
      tick();
      bus.start = 1'b0;
      tick();
      chk("store_e1_memwr", 32'(bus.mem_write), 1);
      chk("store_e1_addr", 32'(bus.mem_address), 'h11);
      chk("store_e1_data", 32'(bus.mem_data), 'h123);
      tick();
      chk("store_e2_memwr", 32'(bus.mem_write), 0);
      chk("store_e2_finished", 32'(bus.finished), 0);
      tick();
      chk("store_e3_finished", 32'(bus.finished), 1);
      chk("store_ram", 32'(ram[16'h0011]), 'h123);
      chk("store_result_hold", 32'(bus.result), 'hABC);

      // RECT with x wrap
      bus.start = 1'b1;
      bus.instruction = mk_rect(8'd254, 7'd10, 3'd3, 5'd2, 5'd1);
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("rect_plot%0d", k), 32'(bus.plot), 1);
         chk($sformatf("rect_x%0d", k), 32'(bus.x), 32'(ex[k]));
         chk($sformatf("rect_y%0d", k), 32'(bus.y), 32'(ey[k]));
      end
      tick();
      chk("rect_end_plot", 32'(bus.plot), 0);
      chk("rect_end_finished", 32'(bus.finished), 1);

      // LOAD 0x5A5 into result, then FILL with address wrap
      bus.start = 1'b1;
      bus.instruction = mk_mem(4'd2, 12'd0, 16'h0020);
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      chk("fill_pre_result", 32'(bus.result), 'h5A5);
      bus.start = 1'b1;
      bus.instruction = mk_mem(4'd5, 12'd3, 16'hFFFE);
      tick();
      bus.start = 1'b0;
      for (int n = 0; n < 4; n++) begin
         tick();
         chk($sformatf("fill_wr%0d", n), 32'(bus.mem_write), 1);
         chk($sformatf("fill_addr%0d", n), 32'(bus.mem_address), 32'(16'(16'hFFFE + n)));
         chk($sformatf("fill_data%0d", n), 32'(bus.mem_data), 'h5A5);
      end
      tick();
      chk("fill_end_memwr", 32'(bus.mem_write), 0);
      chk("fill_end_finished", 32'(bus.finished), 1);
      chk("fill_ram0", 32'(ram[16'h0000]), 'h5A5);

      // FILL full-range count
      bus.start = 1'b1;
      bus.instruction = mk_mem(4'd5, 12'hFFF, 16'h0100);
      tick();
      bus.start = 1'b0;
      wr = 0;
      cyc = 0;
      bad = 0;
      while (!bus.finished && cyc < 5000) begin
         tick();
         cyc++;
         if (bus.mem_write) begin
            if (bus.mem_address !== 16'(16'h0100 + wr)) bad++;
            wr++;
         end
      end
      chk("fillbig_finished", 32'(bus.finished), 1);
      chk("fillbig_count", 32'(wr), 4096);
      chk("fillbig_addr_seq", 32'(bad), 0);
      chk("fillbig_last_addr", 32'(bus.mem_address), 'h10FF);

      // Illegal opcode
      bus.start = 1'b1;
      bus.instruction = 32'hF000_0000;
      tick();
      bus.start = 1'b0;
      chk("ill_e0_finished", 32'(bus.finished), 0);
      tick();
      chk("ill_e1_finished", 32'(bus.finished), 1);
      chk("ill_e1_illegal", 32'(bus.illegal), 1);
      chk("ill_e1_memwr", 32'(bus.mem_write), 0);
      tick();
      chk("ill_sticky", 32'(bus.illegal), 1);

      // Start while busy is ignored; illegal clears on accept
      bus.start = 1'b1;
      bus.instruction = mk_mem(4'd2, 12'd0, 16'h0010);
      tick();
      chk("busy_e0_illegal_clr", 32'(bus.illegal), 0);
      bus.instruction = 32'hF000_0000;
      tick();
      bus.start = 1'b0;
      chk("busy_e1_finished", 32'(bus.finished), 0);
      tick();
      tick();
      chk("busy_e3_finished", 32'(bus.finished), 1);
      chk("busy_e3_result", 32'(bus.result), 'hABC);
      tick();
      chk("busy_e4_illegal", 32'(bus.illegal), 0);
      chk("busy_e4_finished", 32'(bus.finished), 1);

      // start held high: back-to-back accepts with one finished cycle between
      bus.start = 1'b1;
      bus.instruction = mk_plot(8'd7, 7'd1, 3'd1, 1'b1);
      tick();
      chk("b2b_e0_finished", 32'(bus.finished), 0);
      tick();
      chk("b2b_e1_x", 32'(bus.x), 7);
      bus.instruction = mk_plot(8'd9, 7'd2, 3'd2, 1'b1);
      tick();
      chk("b2b_e2_finished", 32'(bus.finished), 1);
      chk("b2b_e2_plot", 32'(bus.plot), 0);
      tick();
      chk("b2b_e3_finished", 32'(bus.finished), 0);
      bus.start = 1'b0;
      tick();
      chk("b2b_e4_plot", 32'(bus.plot), 1);
      chk("b2b_e4_x", 32'(bus.x), 9);
      tick();
      chk("b2b_e5_finished", 32'(bus.finished), 1);

      // Asynchronous reset in the middle of a RECT
      bus.start = 1'b1;
      bus.instruction = mk_rect(8'd20, 7'd30, 3'd6, 5'd3, 5'd3);
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("rrst_pre_plot", 32'(bus.plot), 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("rrst_finished", 32'(bus.finished), 1);
      chk("rrst_plot", 32'(bus.plot), 0);
      chk("rrst_x", 32'(bus.x), 0);
      chk("rrst_y", 32'(bus.y), 0);
      chk("rrst_addr", 32'(bus.mem_address), 0);
      chk("rrst_result", 32'(bus.result), 0);
      tick();
      tick();
      resetn = 1'b1;
      tick();
      bus.start = 1'b1;
      bus.instruction = mk_plot(8'd3, 7'd4, 3'd2, 1'b1);
      tick();
      bus.start = 1'b0;
      tick();
      chk("rrst_plot_pulse", 32'(bus.plot), 1);
      chk("rrst_plot_x", 32'(bus.x), 3);
      chk("rrst_plot_y", 32'(bus.y), 4);
      tick();
      chk("rrst_plot_done", 32'(bus.finished), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/draw_mem_exec_unit.md
Name: draw_mem_exec_unit

Overview:
- Parametrised successor to the single-instruction datapath.
- Executes one instruction per start/finished handshake: pixel plot, memory load, memory store, and two new multi-cycle ops.
  - RECT: fill a rectangle with one pixel per cycle.
  - FILL: write one value to a range of consecutive addresses, one write per cycle.
- Sits between the controller FSM and the VGA adapter / on-chip RAM.
- Widths and memory latency are generics.

Parameters:
- OP_W, 4: opcode width, held in instruction[INSTR_W-1 -: OP_W].
- INSTR_W, 32: instruction width.
- X_W, 8: x coordinate width.
- Y_W, 7: y coordinate width.
- COLOUR_W, 3: colour width.
- ADDR_W, 16: memory address width.
- DATA_W, 12: memory data width; the result register has the same width.
- RECT_W, 5: width of each rectangle dimension field, encoded as size minus 1.
- CNT_W, 12: width of the fill count field, encoded as count minus 1.
- MEM_LATENCY, 2: cycles from address issue to valid mem_output; legal range 1 to 7.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only while finished=1.
- instruction  in  INSTR_W  latched on an accepted start.
- result  out  DATA_W  last loaded word.
- x  out  X_W  pixel x.
- y  out  Y_W  pixel y.
- colour  out  COLOUR_W  pixel colour.
- plot  out  1  pixel write strobe, one cycle per pixel.
- finished  out  1  idle/ready.
- illegal  out  1  last accepted opcode was undefined; sticky until the next accept.
- mem_output  in  DATA_W  RAM read data.
- mem_address  out  ADDR_W  RAM address.
- mem_data  out  DATA_W  RAM write data.
- mem_write  out  1  RAM write enable.

Behaviour:
- Reset (asynchronous, any state, mid-operation included):
  - finished=1.
  - All other outputs 0.
  - Latched instruction and all counters 0.
  - The state machine returns to IDLE.
- Instruction fields, packed LSB-first. All instruction fields below are relative to the instruction latched at accept, never the live instruction input.
  - PLOT and RECT share: x0[X_W-1:0], y0 next Y_W bits, colour next COLOUR_W bits.
  - PLOT: then pen (1 bit).
  - RECT: then wm1 (RECT_W bits), then hm1 (RECT_W bits). Defaults: x 7:0, y 14:8, colour 17:15, pen/wm1 from bit 18.
  - LOAD, STORE and FILL: addr[ADDR_W-1:0].
  - STORE: then data (DATA_W bits).
  - FILL: then cntm1 (CNT_W bits).
- Opcodes: 1 PLOT, 2 LOAD, 3 STORE, 4 RECT, 5 FILL; all others are illegal, including 0.
- States: IDLE, PLOT, MEMWAIT, RECT, FILL.
- Accept:
  - In IDLE with start=1 at edge E0: latch the instruction, set finished=0 and illegal=0, and go to the decoded state.
  - start is ignored while finished=0.
  - start held high re-accepts at the first edge where finished=1 is already registered, so there is at least one idle cycle between instructions.
- Illegal opcode: at E1, finished=1 and illegal=1; no other output changes.
- PLOT:
  - E1: x, y and colour load from the instruction; plot=pen.
  - E2: plot=0 and finished=1.
  - x, y and colour hold their values after completion.
- LOAD:
  - E1: mem_address=addr, mem_write=0.
  - E1+MEM_LATENCY: result captures mem_output, finished=1.
- STORE:
  - E1: mem_address=addr, mem_data=data, mem_write=1.
  - E2: mem_write=0 (single-cycle pulse).
  - E1+MEM_LATENCY: finished=1. When MEM_LATENCY=1, finished=1 and mem_write=0 on the same edge, E2.
- RECT:
  - Pixels are emitted in row-major order, one per cycle, with plot=1 throughout.
  - Pixel k = j·(wm1+1)+i is presented at edge E1+k with x=x0+i and y=y0+j.
  - Additions truncate to X_W and Y_W bits (wrap-around).
  - The edge after the last pixel: plot=0, finished=1.
  - Total pixels = (wm1+1)(hm1+1); the busy time is that count plus 1 cycle.
- FILL:
  - Writes go out one per cycle with mem_write=1 and mem_data=result, the value captured at accept.
  - Write n occurs at edge E1+n with mem_address=addr+n mod 2^ADDR_W, for n = 0 to cntm1.
  - The edge after the last write: mem_write=0, finished=1.
  - Pipelined writes have no latency wait.
- mem_address, mem_data and result hold their values between instructions.
- Counters are sized RECT_W and CNT_W. The terminal compare is on the m1 value, so a full-range count (all ones) must terminate correctly and not overflow into an endless loop.

Test Plan:
- Reset mid-RECT:
  - Stimulus: issue RECT wm1=3, hm1=3, then drop resetn asynchronously between clock edges after 5 pixels.
  - Required: outputs go to zero and finished=1 immediately, without waiting for a clock edge. A following PLOT executes normally.
- PLOT:
  - Stimulus: instruction op=1, x=160, y=120, colour=5, pen=1.
  - Required: exactly one plot pulse at E1 with x=160, y=120, colour=5; finished=1 at E2; x, y and colour still held at E3.
- LOAD then STORE with MEM_LATENCY=2 and a RAM model pre-loaded with 0xABC at 0x0010:
  - Required for LOAD: result=0xABC and finished=1 at E3.
  - Then STORE 0x123 to 0x0011. Required: mem_write high for one cycle only; RAM[0x11]=0x123.
- RECT with wrap:
  - Stimulus: x0=254, y0=10, wm1=2, hm1=1.
  - Required: 6 consecutive plot cycles at x,y = 254,10; 255,10; 0,10; 254,11; 255,11; 0,11; then plot=0 and finished=1.
- FILL:
  - Stimulus: load result=0x5A5, then FILL addr=0xFFFE, cntm1=3.
  - Required: writes of 0x5A5 to 0xFFFE, 0xFFFF, 0x0000, 0x0001 on consecutive cycles; finished=1 on the next edge. Repeat with cntm1=4095 and check for exactly 4096 writes.
- Illegal opcode and handshake:
  - Stimulus: op=0xF.
  - Required: finished=1 and illegal=1 at E1. A start asserted while busy is ignored. start held high gives back-to-back accepts separated by one finished cycle. illegal clears on the next accept.
